// File: rtl/conv_seq_ctrl.sv
// Sequencer for one binary-weight 5x5 convolution pass on conv_mix:
// loads weights, streams pixels, captures results into the result buffer.
module conv_seq_ctrl #(
  parameter int DATA_W  = 16,
  parameter int KTAPS   = 25,
  parameter int AW      = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_layer,
  input  logic [AW-1:0]     cmd_wbase,
  input  logic [AW-1:0]     cmd_ibase,
  input  logic [AW-1:0]     cmd_rbase,
  output logic [AW-1:0]     wmem_addr,
  input  logic              wmem_rdata,
  output logic [AW-1:0]     imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              conv_start,
  output logic              conv_state,
  output logic              conv_weight_en,
  output logic              conv_weight,
  output logic [DATA_W-1:0] conv_din,
  output logic              conv_din_valid,
  input  logic [DATA_W-1:0] conv_dout,
  input  logic              conv_ovalid,
  input  logic              conv_done,
  output logic              rmem_we,
  output logic [AW-1:0]     rmem_addr,
  output logic [DATA_W-1:0] rmem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int KW = $clog2(KTAPS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = 10;

  typedef enum logic [2:0] {
    IDLE, LOAD_W, STREAM, DRAIN, FIN
  } state_t;

  state_t state, state_nx;

  logic          layer;
  logic [AW-1:0] wbase, ibase, rbase;
  logic [KW-1:0] kcnt;
  logic [CW-1:0] pcnt, ocnt, ocnt_nx;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] npix, nexp;
  logic          accept, w_issue, i_issue;
  logic          capture, hit, wr_ok, set_err;
  logic          wen_q, dval_q, tmo;

  assign npix    = layer ? CW'(144) : CW'(784);
  assign nexp    = layer ? CW'(64) : CW'(576);
  assign accept  = (state == IDLE) && cmd_valid;
  assign w_issue = (state == LOAD_W) && !conv_done;
  assign i_issue = (state == STREAM) && !conv_done;
  assign capture = state inside {LOAD_W, STREAM, DRAIN};
  assign hit     = capture && conv_ovalid;
  assign wr_ok   = hit && (ocnt != nexp);
  assign ocnt_nx = ocnt + CW'(wr_ok);
  assign tmo     = (tcnt == TW'(TIMEOUT - 1));

  // Any of: overflow, early done, short count at done, drain timeout.
  assign set_err =
    (hit && !wr_ok) ||
    (conv_done && (state inside {LOAD_W, STREAM})) ||
    ((state == DRAIN) && conv_done && (ocnt_nx != nexp)) ||
    ((state == DRAIN) && !conv_done && tmo);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (cmd_valid) state_nx = LOAD_W;
      LOAD_W: begin
        if (conv_done) state_nx = FIN;
        else if (kcnt == KW'(KTAPS - 1)) state_nx = STREAM;
      end
      STREAM: begin
        if (conv_done) state_nx = FIN;
        else if (pcnt == npix - CW'(1)) state_nx = DRAIN;
      end
      DRAIN:  if (conv_done || tmo) state_nx = FIN;
      FIN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      layer <= 1'b0;
      wbase <= '0;
      ibase <= '0;
      rbase <= '0;
      kcnt  <= '0;
      pcnt  <= '0;
      ocnt  <= '0;
      tcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        layer <= cmd_layer;
        wbase <= cmd_wbase;
        ibase <= cmd_ibase;
        rbase <= cmd_rbase;
        kcnt  <= '0;
        pcnt  <= '0;
        ocnt  <= '0;
        tcnt  <= '0;
        err   <= 1'b0;
      end else begin
        if (w_issue) kcnt <= kcnt + KW'(1);
        if (i_issue) pcnt <= pcnt + CW'(1);
        if (state == DRAIN) tcnt <= tcnt + TW'(1);
        ocnt <= ocnt_nx;
        if (set_err) err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wen_q      <= 1'b0;
      dval_q     <= 1'b0;
      rmem_we    <= 1'b0;
      rmem_addr  <= '0;
      rmem_wdata <= '0;
    end else begin
      wen_q   <= w_issue;
      dval_q  <= i_issue;
      rmem_we <= wr_ok;
      if (wr_ok) begin
        rmem_addr  <= rbase + AW'(ocnt);
        rmem_wdata <= conv_dout;
      end
    end
  end

  assign cmd_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign done           = (state == FIN);
  assign conv_start     = capture;
  assign conv_state     = busy && layer;
  assign wmem_addr      = w_issue ? wbase + AW'(kcnt) : '0;
  assign imem_addr      = i_issue ? ibase + AW'(pcnt) : '0;
  assign conv_weight    = wmem_rdata;
  assign conv_din       = imem_rdata;
  assign conv_weight_en = wen_q;
  assign conv_din_valid = dval_q;

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Sequencer that runs one binary-weight 5x5 convolution pass on the `conv_mix` datapath. It accepts a layer command, bit-serially loads the 25 kernel weights from weight memory, and streams the input feature map from image memory. It also writes every convolution result into the result buffer and checks the result count. It sits between the layer-level top controller and `conv_mix`, replacing the hand-driven stimulus used in unit simulation.

## Interface
- `DATA_W`, default 16: pixel/result width (signed).
- `KTAPS`, default 25: weight bits per kernel (5x5).
- `AW`, default 10: image/result/weight memory address width.
- `TIMEOUT`, default 1023: maximum DRAIN cycles before abort.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_layer` in 1: 0 = 28x28 in / 24x24 out; 1 = 12x12 in / 8x8 out.
- `cmd_wbase` in AW: weight memory base address.
- `cmd_ibase` in AW: image memory base address.
- `cmd_rbase` in AW: result memory base address.
- `wmem_addr` out AW, `wmem_rdata` in 1: weight read port, 1-cycle read latency.
- `imem_addr` out AW, `imem_rdata` in DATA_W: image read port, 1-cycle read latency.
- `conv_start` out 1, `conv_state` out 1, `conv_weight_en` out 1, `conv_weight` out 1, `conv_din` out DATA_W, `conv_din_valid` out 1: drive `conv_mix`.
- `conv_dout` in DATA_W, `conv_ovalid` in 1, `conv_done` in 1: from `conv_mix`.
- `rmem_we` out 1, `rmem_addr` out AW, `rmem_wdata` out DATA_W: result write port.
- `busy` out 1: high when not IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky error flag for the last pass. Cleared on the next command accept.

## Operation
- States: IDLE -> LOAD_W -> STREAM -> DRAIN -> FIN -> IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `layer`, `wbase`, `ibase` and `rbase`, clear `err` and the counters, then go to LOAD_W.
- LOAD_W: issue `wmem_addr` = wbase+k for k = 0..24, one address per cycle. After k = 24, go to STREAM.
- Weight data path: `conv_weight_en` is the address-issue flag delayed by one register. `conv_weight` = `wmem_rdata`, passed through combinationally.
- STREAM: issue `imem_addr` = ibase+p for p = 0..N*N-1, where N = 28 for layer 0 and 12 for layer 1. After the last pixel, go to DRAIN.
- Image data path: `conv_din_valid` is the issue flag delayed by one cycle. `conv_din` = `imem_rdata`.
- `conv_start` is high from LOAD_W entry until FIN, and low otherwise. `conv_state` = latched layer while busy, 0 in IDLE.
- Result capture: in LOAD_W, STREAM and DRAIN, each cycle with `conv_ovalid`=1 registers a write with `rmem_we`=1, `rmem_addr` = rbase+ocnt and `rmem_wdata` = `conv_dout`. `ocnt` then increments.
- Expected result count: E = 576 (layer 0) or 64 (layer 1).
- Normal completion: `conv_done`=1 sampled in DRAIN goes to FIN. The same-cycle `conv_ovalid` result is written. If the final ocnt != E, set `err`.
- Early done: `conv_done` in LOAD_W or STREAM sets `err`, stops issuing addresses and goes to FIN.
- Overflow: an `ocnt` that would reach E+1 suppresses the write and sets `err`.
- Timeout: more than TIMEOUT cycles in DRAIN without `conv_done` sets `err` and goes to FIN.
- FIN: `done`=1 for one cycle, then IDLE.
- `conv_done`/`conv_ovalid` while IDLE are ignored (no write).
- Reset: asynchronous return to IDLE from any state, abandoning any pass.

## Timing
- Reset values: `cmd_ready`=1. All other outputs are 0, including all addresses, `rmem_wdata` and `err`.
- Command accepted at cycle c: LOAD_W occupies c+1..c+25, with `wmem_addr` = wbase..wbase+24.
- `conv_weight_en` is high during c+2..c+26 (exactly 25 cycles).
- STREAM occupies c+26..c+25+N*N, and `conv_din_valid` lags each address by one cycle.
- Layer 0: STREAM spans c+26..c+809. Layer 1: STREAM spans c+26..c+169.
- Result writes appear one cycle after the `conv_ovalid` that produced them.
- `done` asserts one cycle after the `conv_done` sample.
- Back-to-back commands: the earliest next accept is the cycle after `done`.

## Test plan
- Layer 0, behavioural `conv_mix` model producing 576 results: exactly 25 `conv_weight_en` cycles and 784 `conv_din_valid` cycles. Result addresses run rbase..rbase+575, `done` pulses once, `err`=0.
- Layer 1, rbase=100: 144 pixels streamed, 64 writes to addresses 100..163, `conv_state`=1 throughout, `err`=0.
- Model asserts `conv_done` after 63 results: `done` pulses and `err`=1.
- Model never asserts `conv_done`: after 1023 DRAIN cycles, `done`=1, `err`=1, then `cmd_ready`=1.
- `rstn` pulsed low mid-STREAM (pixel 300): all outputs return to reset values immediately. A new command then runs cleanly with `err`=0.
- `cmd_valid` held high continuously: second pass accepted the cycle after `done`, and `err` is cleared at that accept.
